// File: rtl/point_weights_fetch.sv
// Burst reader for weight rows; streams rows through a 2-entry FIFO.
// Optional range check on the burst: define POINT_FETCH_BOUND_CHECK_EN.
module point_weights_fetch #(
  parameter int Data_Width = 14,
  parameter int height     = 938,
  parameter int Row_Values = 256,
  parameter int Addr_Width = 10,
  localparam int W = Row_Values * Data_Width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [Addr_Width-1:0] base_index,
  input  logic [Addr_Width-1:0] row_count,
  output logic                  mem_en,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [Addr_Width-1:0] mem_index,
  input  logic [W-1:0]          mem_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [W-1:0]          w_data,
  output logic                  w_last,
  output logic                  busy,
  output logic                  done
`ifdef POINT_FETCH_BOUND_CHECK_EN
  ,output logic                 err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [Addr_Width-1:0] ONE = Addr_Width'(1);

  state_t                state;
  logic [Addr_Width-1:0] base_q;
  logic [Addr_Width-1:0] cnt;
  logic [Addr_Width-1:0] n;
  logic                  rd_last;

  logic [1:0]            occ;
  logic [1:0]            occ_nx;
  logic [W-1:0]          d0;
  logic [W-1:0]          d1;
  logic                  l0;
  logic                  l1;

  logic                  pop;
  logic                  push;
  logic                  can_issue;
  logic                  oob;

  assign mem_en = mem_rd;
  assign mem_wr = 1'b0;
  assign w_data = d0;
  assign w_last = w_valid & l0;

`ifdef POINT_FETCH_BOUND_CHECK_EN
  logic [31:0] span;
  assign span = 32'(base_index) + 32'(row_count);
  assign oob  = span > 32'(height);
`else
  assign oob  = 1'b0;
`endif

  // A read in flight always lands at the next edge, so it is
  // already folded into occ_nx when deciding on the next read.
  always_comb begin
    pop       = w_valid & w_ready;
    push      = mem_rd;
    occ_nx    = occ + {1'b0, push} - {1'b0, pop};
    can_issue = occ_nx < 2'd2;
  end

  // Burst control: address generation, state and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base_q    <= '0;
      cnt       <= '0;
      n         <= '0;
      rd_last   <= 1'b0;
      mem_rd    <= 1'b0;
      mem_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef POINT_FETCH_BOUND_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      mem_rd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base_index;
            cnt     <= row_count;
            n       <= '0;
            rd_last <= 1'b0;
            if (oob) begin
              state <= DONE;
              done  <= 1'b1;
`ifdef POINT_FETCH_BOUND_CHECK_EN
              err   <= 1'b1;
`endif
            end else if (row_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= FETCH;
              busy      <= 1'b1;
              mem_rd    <= 1'b1;
              mem_index <= base_index;
              n         <= ONE;
              rd_last   <= (row_count == ONE);
            end
          end
        end
        FETCH: begin
          if (n == cnt) begin
            state <= DRAIN;
          end else if (can_issue) begin
            mem_rd    <= 1'b1;
            mem_index <= base_q + n;
            n         <= n + ONE;
            rd_last   <= (n + ONE == cnt);
          end
        end
        DRAIN: begin
          if (occ_nx == 2'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
`ifdef POINT_FETCH_BOUND_CHECK_EN
          err   <= 1'b0;
`endif
        end
      endcase
    end
  end

  // Two-slot FIFO with the head always in slot 0 so w_data is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ     <= '0;
      d0      <= '0;
      d1      <= '0;
      l0      <= 1'b0;
      l1      <= 1'b0;
      w_valid <= 1'b0;
    end else begin
      occ     <= occ_nx;
      w_valid <= occ_nx != 2'd0;
      if (pop && occ == 2'd2) begin
        d0 <= d1;
        l0 <= l1;
        if (push) begin
          d1 <= mem_data;
          l1 <= rd_last;
        end
      end else if (push) begin
        if (pop || occ == 2'd0) begin
          d0 <= mem_data;
          l0 <= rd_last;
        end else begin
          d1 <= mem_data;
          l1 <= rd_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_point_weights_fetch.sv
// Directed bench for point_weights_fetch.
// Memory model returns a per-row pattern for the current mem_index.
module tb_point_weights_fetch;

  localparam int AW = 10;
  localparam int W  = 256 * 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_index = '0;
  logic [AW-1:0] row_count = '0;
  logic          mem_en;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_index;
  logic [W-1:0]  mem_data;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [W-1:0]  w_data;
  logic          w_last;
  logic          busy;
  logic          done;
`ifdef POINT_FETCH_BOUND_CHECK_EN
  logic          err;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  point_weights_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_index(base_index),
    .row_count (row_count),
    .mem_en    (mem_en),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_index (mem_index),
    .mem_data  (mem_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_last    (w_last),
    .busy      (busy),
    .done      (done)
`ifdef POINT_FETCH_BOUND_CHECK_EN
    ,.err      (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input logic [AW-1:0] r);
    logic [31:0] word;
    word = {6'd0, r, 6'd0, ~r};
    return {(W/32){word}};
  endfunction

  assign mem_data = pat(mem_index);

  always @(posedge clk) begin
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [AW-1:0] b,
                       input logic [AW-1:0] c,
                       input logic mid_start);
    int r0, d0;
    logic [AW-1:0] r;
    r0 = rd_cnt;
    d0 = done_cnt;
    w_ready = 1'b1;
    start = 1'b1;
    base_index = b;
    row_count = c;
    step();
    start = 1'b0;
    check("first_rd", mem_rd, 1);
    check("first_en", mem_en, 1);
    check("first_idx", mem_index, b);
    check("first_vld", w_valid, 0);
    for (int i = 0; i < int'(c); i++) begin
      step();
      if (mid_start && i == 1) start = 1'b0;
      r = b + AW'(i);
      check("row_vld", w_valid, 1);
      check("row_data", w_data, pat(r));
      check("row_last", w_last, (i == int'(c) - 1));
      check("row_busy", busy, 1);
      if (mid_start && i == 0) begin
        start = 1'b1;
        base_index = 10'd100;
        row_count = 10'd2;
      end
    end
    step();
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_vld", w_valid, 0);
    step();
    check("end_done2", done, 0);
    check("end_rds", rd_cnt - r0, int'(c));
    check("end_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int r0, d0;
    step();
    step();
    check("rst_ctl", {mem_en, mem_rd, mem_wr, w_valid, w_last, busy, done}, 0);
    check("rst_idx", mem_index, 0);
    check("rst_data", w_data, 0);
    rst = 1'b1;
    step();

    // Basic burst at row 0.
    burst(10'd0, 10'd4, 1'b0);

    // Backpressure: consumer stalls while the FIFO fills.
    r0 = rd_cnt;
    d0 = done_cnt;
    w_ready = 1'b0;
    start = 1'b1;
    base_index = 10'd10;
    row_count = 10'd3;
    step();
    start = 1'b0;
    check("bp_rd0", mem_rd, 1);
    check("bp_idx0", mem_index, 10);
    step();
    check("bp_rd1", mem_rd, 1);
    check("bp_idx1", mem_index, 11);
    check("bp_vld", w_valid, 1);
    check("bp_data", w_data, pat(10'd10));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_stall_rd", mem_rd, 0);
      check("bp_stall_vld", w_valid, 1);
      check("bp_stall_data", w_data, pat(10'd10));
      check("bp_stall_last", w_last, 0);
    end
    check("bp_rds_stalled", rd_cnt - r0, 2);
    w_ready = 1'b1;
    step();
    check("bp_r11", w_data, pat(10'd11));
    check("bp_r11_last", w_last, 0);
    check("bp_rd2", mem_rd, 1);
    check("bp_idx2", mem_index, 12);
    step();
    check("bp_r12", w_data, pat(10'd12));
    check("bp_r12_last", w_last, 1);
    step();
    check("bp_done", done, 1);
    check("bp_vld_end", w_valid, 0);
    step();
    check("bp_done2", done, 0);
    check("bp_rds", rd_cnt - r0, 3);
    check("bp_pulses", done_cnt - d0, 1);

    // Empty burst.
    r0 = rd_cnt;
    d0 = done_cnt;
    start = 1'b1;
    base_index = 10'd7;
    row_count = 10'd0;
    step();
    start = 1'b0;
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    check("z_rd", mem_rd, 0);
    step();
    check("z_done2", done, 0);
    check("z_busy2", busy, 0);
    check("z_rds", rd_cnt - r0, 0);
    check("z_pulses", done_cnt - d0, 1);

    // Reset in the middle of a burst.
    start = 1'b1;
    base_index = 10'd20;
    row_count = 10'd8;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("mr_row2", w_data, pat(10'd22));
    rst = 1'b0;
    #1;
    check("mr_ctl", {mem_en, mem_rd, mem_wr, w_valid, w_last, busy, done}, 0);
    check("mr_idx", mem_index, 0);
    check("mr_data", w_data, 0);
    step();
    check("mr_ctl2", {mem_rd, w_valid, busy, done}, 0);
    rst = 1'b1;
    step();
    check("mr_idle", {mem_rd, w_valid, busy, done}, 0);
    burst(10'd5, 10'd1, 1'b0);

    // Start pulsed mid-burst must be ignored.
    burst(10'd40, 10'd4, 1'b1);

`ifdef POINT_FETCH_BOUND_CHECK_EN
    r0 = rd_cnt;
    start = 1'b1;
    base_index = 10'd930;
    row_count = 10'd10;
    step();
    start = 1'b0;
    check("oob_done", done, 1);
    check("oob_err", err, 1);
    check("oob_rd", mem_rd, 0);
    check("oob_busy", busy, 0);
    step();
    check("oob_done2", done, 0);
    check("oob_err2", err, 0);
    check("oob_rds", rd_cnt - r0, 0);
    burst(10'd928, 10'd10, 1'b0);
    check("ok_err", err, 0);
`else
    // Address wraps modulo 2^AW.
    burst(10'd1022, 10'd3, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
